rcvr_scheduler: RTL

Round-robin read scheduler for a bank of `NCH` serial-to-parallel receivers (`rcvr`).
- Watches each receiver's `ready`/`overrun`, issues one-cycle `reading` strobes one channel at a time, and captures the byte.
- Tags each byte with its channel number and overrun status, then buffers it in a `DEPTH`-entry FIFO with a valid/ready output port.
- Sits between the receiver bank and the downstream packet consumer.

---
 rtl/rcvr_scheduler_if.sv | 27 ++
 rtl/rcvr_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rcvr_scheduler_if.sv
// Receiver-bank and output-FIFO signal bundle for rcvr_scheduler.
// The master side is the scheduler; the slave side is the receivers plus the consumer.
interface rcvr_scheduler_if #(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
);
    logic [NCH-1:0]   rx_ready;
    logic [NCH-1:0]   rx_overrun;
    logic [NCH*8-1:0] rx_data;
    logic [NCH-1:0]   rx_reading;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [CW-1:0]    out_chan;
    logic             out_ovr;

    modport master (
        input  rx_ready, rx_overrun, rx_data, out_ready,
        output rx_reading, out_valid, out_data, out_chan, out_ovr
    );

    modport slave (
        output rx_ready, rx_overrun, rx_data, out_ready,
        input  rx_reading, out_valid, out_data, out_chan, out_ovr
    );
endinterface

// File: rtl/rcvr_scheduler.sv
// Round-robin read scheduler for a bank of serial receivers, feeding a tagged
// byte FIFO with a valid/ready output port.
module rcvr_scheduler #(
    parameter int NCH   = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(NCH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    ovr_clear,
    output logic [NCH-1:0]          ovr_sticky,
    output logic [$clog2(DEPTH):0]  fifo_count,
    rcvr_scheduler_if.master        bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic {
        SCAN,
        READ
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  last_q;
    logic [CW-1:0]  pick;
    logic           pick_found;
    logic [NCH-1:0] reading_q;
    logic [NCH-1:0] reading_d;
    logic           grant;
    logic           push;
    logic           pop;
    logic           push_ovr;
    logic [7:0]     push_data;
    logic [NCH-1:0] sticky_d;
    logic [7:0]     rx_bytes [NCH];
    int             idx;

    logic [7:0]     mem_data [DEPTH];
    logic [CW-1:0]  mem_chan [DEPTH];
    logic           mem_ovr  [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            rx_bytes[i] = bus.rx_data[8*i +: 8];
        end
    end

    // Search from the channel after the last winner, wrapping around once.
    always_comb begin
        pick       = last_q;
        pick_found = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last_q) + k) % NCH;
            if (!pick_found && bus.rx_ready[idx]) begin
                pick       = CW'(idx);
                pick_found = 1'b1;
            end
        end
    end

    assign grant = (state_q == SCAN) && enable && (fifo_count < FULL_COUNT) && pick_found;

    always_comb begin
        state_d   = state_q;
        reading_d = '0;
        case (state_q)
            SCAN: begin
                if (grant) begin
                    state_d         = READ;
                    reading_d[pick] = 1'b1;
                end
            end
            READ: begin
                state_d = SCAN;
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // last_q doubles as the in-flight channel while in READ.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SCAN;
            reading_q <= '0;
            last_q    <= CW'(NCH - 1);
        end else begin
            state_q   <= state_d;
            reading_q <= reading_d;
            if (grant) begin
                last_q <= pick;
            end
        end
    end

    assign push      = (state_q == READ);
    assign pop       = bus.out_valid && bus.out_ready;
    assign push_ovr  = bus.rx_overrun[last_q];
    assign push_data = rx_bytes[last_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_chan[i] <= '0;
                mem_ovr[i]  <= 1'b0;
            end
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem_data[wptr] <= push_data;
                mem_chan[wptr] <= last_q;
                mem_ovr[wptr]  <= push_ovr;
                wptr           <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A capture in the same cycle as a clear still leaves its bit set.
    always_comb begin
        sticky_d = ovr_clear ? '0 : ovr_sticky;
        if (push && push_ovr) begin
            sticky_d[last_q] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_sticky <= '0;
        end else begin
            ovr_sticky <= sticky_d;
        end
    end

    assign bus.rx_reading = reading_q;
    assign bus.out_valid  = (fifo_count != '0);
    assign bus.out_data   = mem_data[rptr];
    assign bus.out_chan   = mem_chan[rptr];
    assign bus.out_ovr    = mem_ovr[rptr];

endmodule
